fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_buffer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch buffer.
//   PC_W, INST_W, INST_BYTES : address width, instruction width, bytes per fetch.
//   fetch_state_e            : request FSM state (IDLE, BUSY, DRAIN).
//   fetch_entry_t            : one buffered {instruction, address} pair.
//   next_pc()                : sequential fetch address; wraps modulo 2^PC_W.
package fetch_pkg;

    localparam int PC_W       = 64;
    localparam int INST_W     = 32;
    localparam int INST_BYTES = 4;

    // IDLE : no request on the memory port
    // BUSY : request outstanding, its data will be kept
    // DRAIN: request outstanding, its data will be thrown away
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(INST_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO holding {instruction, pc} entries for the fetch buffer.
// Ports:
//   clk, rst              : clock and synchronous active-high reset (pointers/count only)
//   push, push_inst/pc    : write one entry at the tail
//   pop                   : retire the head entry
//   flush                 : discard every entry (takes priority over push/pop)
//   head_inst, head_pc    : current head entry (undefined when count == 0)
//   count                 : number of valid entries, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [INST_W-1:0]       push_inst,
    input  logic [PC_W-1:0]         push_pc,
    input  logic                    pop,
    input  logic                    flush,
    output logic [INST_W-1:0]       head_inst,
    output logic [PC_W-1:0]         head_pc,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{inst: push_inst, pc: push_pc};
        end
    end

    assign head_inst = mem[rd_ptr].inst;
    assign head_pc   = mem[rd_ptr].pc;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
        (push && !pop) |-> (count != FULL_C));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush)
        pop |-> (count != '0));

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: fetches sequential 32-bit words from instruction
// memory into a DEPTH-entry FIFO and presents the head to the decode stage.
// Ports:
//   CLK, reset            : clock, synchronous active-high reset
//   startpc               : fetch address loaded while reset is high
//   redirect, redirect_pc : taken branch; flush buffer and refetch from redirect_pc
//   imem_req/addr         : memory read request and its byte address
//   imem_ack/data         : memory response (only meaningful while imem_req=1)
//   inst_valid/inst/pc    : head entry presented to the consumer
//   inst_ready            : consumer takes the head entry this cycle
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [PC_W-1:0]   startpc,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              inst_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic [PC_W-1:0]   fetch_pc;
    logic [PC_W-1:0]   drain_addr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  occ;
    logic [INST_W-1:0] head_inst;
    logic [PC_W-1:0]   head_pc;
    logic              room_now;
    logic              room_after_push;
    logic              ack;
    logic              push;
    logic              pop;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (reset),
        .push      (push),
        .push_inst (imem_data),
        .push_pc   (fetch_pc),
        .pop       (pop),
        .flush     (redirect),
        .head_inst (head_inst),
        .head_pc   (head_pc),
        .count     (count)
    );

    // Consumer side. Outputs are forced to zero while reset is high, even in
    // the reset cycle itself before the FIFO count has been cleared.
    assign inst_valid = !reset && (count != '0);
    assign inst       = inst_valid ? head_inst : '0;
    assign inst_pc    = inst_valid ? head_pc   : '0;
    assign pop        = inst_valid && inst_ready && !redirect;

    // Occupancy once this cycle's pop has been taken into account. A new
    // request needs one free slot; continuing after an ack needs a slot to
    // remain free after that ack's push.
    assign occ             = count - CNT_W'(pop);
    assign room_now        = occ < CNT_W'(DEPTH);
    assign room_after_push = occ < CNT_W'(DEPTH - 1);

    assign ack  = imem_req && imem_ack;
    assign push = ack && (state != DRAIN) && !redirect;

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                // IDLE raises its request combinationally, so the memory may
                // answer in the same cycle and fetch continues back-to-back.
                if (imem_req) begin
                    state_nxt = (ack && !room_after_push) ? IDLE : BUSY;
                end
            end
            BUSY: begin
                if (redirect) begin
                    state_nxt = ack ? IDLE : DRAIN;
                end else if (ack) begin
                    state_nxt = room_after_push ? BUSY : IDLE;
                end
            end
            DRAIN: begin
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = '0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    // No fresh request while redirecting: fetch_pc is about
                    // to change underneath it.
                    if (!redirect && room_now) begin
                        imem_req  = 1'b1;
                        imem_addr = fetch_pc;
                    end
                end
                BUSY: begin
                    imem_req  = 1'b1;
                    imem_addr = fetch_pc;
                end
                DRAIN: begin
                    imem_req  = 1'b1;
                    imem_addr = drain_addr;
                end
                default: begin
                    imem_req  = 1'b0;
                    imem_addr = '0;
                end
            endcase
        end
    end

    // Fetch address: restart value under reset, branch target on redirect,
    // otherwise advance by one instruction per kept response.
    always_ff @(posedge CLK) begin
        if (reset) begin
            fetch_pc <= startpc;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
        end else if (push) begin
            fetch_pc <= next_pc(fetch_pc);
        end
    end

    // fetch_pc is overwritten by the redirect, so the still-outstanding
    // address is kept here to hold imem_addr stable through DRAIN.
    always_ff @(posedge CLK) begin
        if ((state == BUSY) && redirect && !ack) begin
            drain_addr <= fetch_pc;
        end
    end

endmodule
